// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the four requesters and the round-robin arbiter.
// The arbiter side uses the master modport; the requester side uses slave.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] gnt_idx;
    logic       dec_en_n;
    logic       busy;
    logic       timeout;

    modport master (
        input  req, done,
        output grant, gnt_idx, dec_en_n, busy, timeout
    );

    modport slave (
        output req, done,
        input  grant, gnt_idx, dec_en_n, busy, timeout
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter driving a 2-to-4 select decoder (index + active-low enable).
// Grants are held until the owner releases or MAX_HOLD cycles elapse, then one gap cycle.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input logic           clk,
    input logic           rst,
    rr_arbiter4_if.master bus
);
    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [7:0] hold_cnt_q;
    logic [1:0] win;
    logic       coop_rel;
    logic       hold_rel;

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        win = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                win = ptr_q + 2'(k);
            end
        end
    end

    assign coop_rel = !bus.req[bus.gnt_idx] || bus.done;
    assign hold_rel = (hold_cnt_q == HoldLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= 2'd3;
            hold_cnt_q   <= 8'd0;
            bus.grant    <= 4'b0000;
            bus.gnt_idx  <= 2'd0;
            bus.dec_en_n <= 1'b1;
            bus.busy     <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    bus.timeout <= 1'b0;
                    if (|bus.req) begin
                        bus.grant    <= 4'b0001 << win;
                        bus.gnt_idx  <= win;
                        bus.dec_en_n <= 1'b0;
                        bus.busy     <= 1'b1;
                        ptr_q        <= win;
                        hold_cnt_q   <= 8'd0;
                        state_q      <= StGrant;
                    end
                end
                StGrant: begin
                    if (coop_rel || hold_rel) begin
                        bus.grant    <= 4'b0000;
                        bus.dec_en_n <= 1'b1;
                        bus.busy     <= 1'b0;
                        // A cooperative release on the limit cycle is not a timeout.
                        bus.timeout  <= !coop_rel;
                        state_q      <= StGap;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                StGap: begin
                    bus.timeout <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    bus.grant    <= 4'b0000;
                    bus.dec_en_n <= 1'b1;
                    bus.busy     <= 1'b0;
                    bus.timeout  <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomized and directed stimulus for rr_arbiter4, checked by a cycle-level owner/gap model
// through an expected-output queue popped by an independent monitor.
module tb_rr_arbiter4;
    localparam int MaxHold = 4;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       en_n;
        logic       busy;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rr_arbiter4_if bus ();

    rr_arbiter4 #(.MAX_HOLD(MaxHold)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: who owns the resource, for how long, and whether a gap is pending.
    int m_owner = -1;
    int m_last  = 3;
    int m_held  = 0;
    int m_idx   = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_owner = -1; m_last = 3; m_held = 0; m_idx = 0; m_gap = 0; m_to = 0;
        end else if (m_gap) begin
            m_gap = 0; m_to = 0;
        end else if (m_owner >= 0) begin
            if (!bus.req[m_owner] || bus.done || m_held >= MaxHold) begin
                m_to    = bus.req[m_owner] && !bus.done;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else begin
            m_to = 0;
            for (int k = 1; k <= 4; k++) begin
                int w;
                w = (m_last + k) % 4;
                if (m_owner < 0 && bus.req[w]) begin
                    m_owner = w; m_last = w; m_idx = w; m_held = 1;
                end
            end
        end
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.idx   = 2'(m_idx);
        e.en_n  = (m_owner < 0);
        e.busy  = (m_owner >= 0);
        e.to    = m_to;
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #1;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL queue_empty at %0t: no expected entry", $time);
        end else begin
            e = exp_q.pop_front();
            a = {bus.grant, bus.gnt_idx, bus.dec_en_n, bus.busy, bus.timeout};
            if (a !== e) begin
                mismatched++;
                $display("FAIL outputs at %0t: got grant=%b idx=%0d en_n=%b busy=%b to=%b, want grant=%b idx=%0d en_n=%b busy=%b to=%b",
                         $time, a.grant, a.idx, a.en_n, a.busy, a.to,
                         e.grant, e.idx, e.en_n, e.busy, e.to);
            end
        end
    end

    task automatic wait_grant(input logic [3:0] g, input string name);
        int n;
        n = 0;
        while (bus.grant !== g && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.grant !== g) begin
            compared++;
            mismatched++;
            $display("FAIL %s: grant=%b never reached %b within bound", name, bus.grant, g);
        end
    endtask

    initial begin
        int run;
        bus.req  = 4'b1111;
        bus.done = 1'b1;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        bus.done = 1'b0;
        repeat (3) @(negedge clk);

        // Single requester, then release by dropping the request.
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);
        bus.req = 4'b0100;
        repeat (3) @(negedge clk);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Round robin with done in each grant's second cycle.
        bus.req = 4'b1111;
        run = 0;
        for (int i = 0; i < 24; i++) begin
            run = bus.busy ? run + 1 : 0;
            bus.done = (run == 2);
            @(negedge clk);
        end
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        repeat (3) @(negedge clk);

        // Hold-limit timeout with a sole requester.
        bus.req = 4'b0010;
        repeat (16) @(negedge clk);

        // done on the limit cycle: cooperative release wins.
        run = 0;
        for (int i = 0; i < 16; i++) begin
            run = bus.busy ? run + 1 : 0;
            bus.done = (run == MaxHold);
            @(negedge clk);
        end
        bus.done = 1'b0;

        // Reset mid-grant returns priority to requester 0.
        bus.req = 4'b1000;
        wait_grant(4'b1000, "reach_grant_1000");
        bus.req = 4'b1001;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.req  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) bus.req = bus.req | 4'b0001 << $urandom_range(0, 3);
            bus.done = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst      = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one 2-to-4 one-hot select decoder (2-bit index plus active-low enable) between four requesters. It picks one requester at a time, drives the decoder's index and enable, and holds the grant until the owner releases it or a hold-time limit expires. It sits directly in front of the decoder and sequences all accesses to the decoded resource.

## Interface
- MAX_HOLD, 15: maximum consecutive grant cycles per owner; legal range 1..255.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request bits; req[i] high = requester i wants the resource.
- done  input  1  owner-driven release pulse; sampled only in GRANT.
- grant  output  4  registered one-hot grant; 4'b0000 when no owner.
- gnt_idx  output  2  registered index of current or last owner; drives the decoder's index input.
- dec_en_n  output  1  registered active-low decoder enable; 0 exactly when grant is non-zero.
- busy  output  1  registered; 1 while in GRANT.
- timeout  output  1  registered one-cycle pulse when a grant is ended by MAX_HOLD.

## Operation
- State machine with states IDLE, GRANT and GAP. Internal 2-bit last-winner pointer ptr and 8-bit hold counter hold_cnt.
- Reset, which overrides everything:
  - state = IDLE; grant = 0000; gnt_idx = 00; dec_en_n = 1; busy = 0; timeout = 0; ptr = 3; hold_cnt = 0.
- IDLE:
  - If req == 0000, stay in IDLE with outputs off.
  - Otherwise, search ptr+1, ptr+2, ptr+3, ptr+4 (mod 4) and take the first index w with req[w] = 1.
  - At the same edge: grant = one-hot(w); gnt_idx = w; dec_en_n = 0; busy = 1; ptr = w; hold_cnt = 0; go to GRANT.
  - done is ignored in IDLE.
- GRANT: evaluated at each edge.
  - Release occurs when req[gnt_idx] = 0, or done = 1, or hold_cnt == MAX_HOLD-1.
  - On release: grant = 0000; dec_en_n = 1; busy = 0; go to GAP. gnt_idx keeps its value.
  - timeout = 1 on the release edge only when the release is caused solely by the hold limit, with req[gnt_idx] = 1 and done = 0. A cooperative release takes precedence over timeout.
  - With no release: hold_cnt increments; the other req bits are ignored.
- GAP:
  - Lasts one cycle with all outputs off; timeout returns to 0.
  - Next state is always IDLE.
- Invariants:
  - grant always equals the decoder output for (gnt_idx, dec_en_n), i.e. one-hot(gnt_idx) when dec_en_n = 0, else 0000.
  - grant never has more than one bit set.
  - The sole requester is re-granted after its release (the round-robin search wraps to it).

## Timing
- Grant latency: request seen in IDLE at edge N → grant valid after edge N, i.e. one cycle later.
- Hold length: a grant lasts at most MAX_HOLD cycles. With MAX_HOLD = 1, every grant lasts exactly 1 cycle and ends with timeout, unless the owner releases first.
- Release latency: release condition sampled at edge N → grant = 0 after edge N.
- Turnaround: release edge → GAP → IDLE → next grant. There are exactly 2 cycles with grant = 0000 between back-to-back grants.
- Fairness: with all four requesters continuously active, each is granted once in every 4 grants.
- Reset mid-grant: grant drops on the next edge, and ptr returns to 3, so requester 0 has top priority afterwards.

## Test plan
- Reset: rst = 1 for 2 cycles with req = 1111 and done = 1 → grant = 0000, gnt_idx = 00, dec_en_n = 1, busy = 0, timeout = 0. After rst falls, the first grant is 0001.
- Single requester: req = 0100 from IDLE → grant = 0100, gnt_idx = 10, dec_en_n = 0, busy = 1 one cycle later. Drop req[2] → grant = 0000 after the next edge, with no timeout.
- Round-robin: req = 1111 held, done pulsed in each grant's second cycle → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant is 2 cycles long, separated by 2 zero cycles.
- Timeout: MAX_HOLD = 4, req = 0010 held, done = 0 → grant 0010 high exactly 4 cycles. timeout = 1 for one cycle coincident with the first grant = 0000 cycle. Grant 0010 is re-asserted after 2 zero cycles.
- Release collision: MAX_HOLD = 4, done = 1 in the 4th grant cycle → grant drops on that edge with timeout = 0.
- Reset mid-operation: during grant 1000, pulse rst for 1 cycle with req = 1001 held → grant = 0000 after the reset edge, then grant 0001 (not 1000) one cycle after rst deasserts.
